// File: rtl/dbi_pkg.sv
// -----------------------------------------------------------------------------
// dbi_pkg
// Shared definitions for the DBI link blocks (encoder and decoder):
//   - skid_state_t : occupancy states of the 2-entry output skid buffer
//   - half_of()    : WIDTH/2 threshold used by the DC-DBI rule
//   - popcount()   : number of ones in a word of up to POP_MAX_W bits
// No ports; import with `import dbi_pkg::*;`.
// -----------------------------------------------------------------------------
package dbi_pkg;

    // Widest word popcount() accepts; narrower words are zero-extended by the
    // caller, and the unused upper bits fold away in synthesis.
    localparam int POP_MAX_W = 256;
    localparam int POP_CNT_W = $clog2(POP_MAX_W) + 1;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_FULL
    } skid_state_t;

    function automatic int half_of(input int width);
        return width / 2;
    endfunction

    function automatic logic [POP_CNT_W-1:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [POP_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            cnt = cnt + POP_CNT_W'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/dbi_decoder_skid_buffer_2.sv
// -----------------------------------------------------------------------------
// skid_buffer_2
// Two-entry strict-FIFO skid buffer with valid/ready on both sides.
// The head register drives out_data directly; the skid register catches one
// extra word while the downstream stalls. in_ready is registered so the
// upstream never sees a combinational path from out_ready.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    upstream handshake (in_ready registered)
//   in_data              word to store
//   out_valid/out_ready  downstream handshake
//   out_data             head-of-queue word
// -----------------------------------------------------------------------------
module skid_buffer_2
    import dbi_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_t      state_q, state_d;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_ready_q;
    logic             accept;
    logic             emit;

    assign accept    = in_valid && in_ready_q;
    assign emit      = (state_q != SKID_EMPTY) && out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != SKID_EMPTY);
    assign out_data  = head_q;

    // NOTE: next_state gets a default first so no path leaves it unassigned;
    // otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SKID_EMPTY: if (accept) state_d = SKID_ONE;
            SKID_ONE: begin
                if (accept && !emit)      state_d = SKID_FULL;
                else if (!accept && emit) state_d = SKID_EMPTY;
            end
            SKID_FULL:  if (emit) state_d = SKID_ONE;
            default:    state_d = SKID_EMPTY;
        endcase
    end

    // NOTE: state and data registers use non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= SKID_EMPTY;
            in_ready_q <= 1'b0;
            // NOTE: the two storage words are reset as well; they are flops,
            // not a RAM, and out_data must read zero after reset.
            head_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != SKID_FULL);
            unique case (state_q)
                SKID_EMPTY: if (accept) head_q <= in_data;
                SKID_ONE: begin
                    // Accept with emit replaces the head; accept alone parks
                    // the new word behind it.
                    if (accept && emit) head_q <= in_data;
                    else if (accept)    skid_q <= in_data;
                end
                SKID_FULL:  if (emit) head_q <= skid_q;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dbi_decoder.sv
// -----------------------------------------------------------------------------
// dbi_decoder
// Receive-side Data Bus Inversion decoder. Restores the original word
// (inverting when in_dbi is set), checks the DC-DBI rule on every accepted
// word, and forwards decoded words through a 2-entry skid buffer.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    upstream handshake (in_ready registered)
//   in_data, in_dbi      transmitted word and its inversion flag
//   out_valid/out_ready  downstream handshake
//   out_data             decoded word
//   err_pulse            one-cycle pulse after a rule-violating accept
//   err_count            saturating violation count
//   clear_err            synchronous clear of err_count (wins over increment)
// -----------------------------------------------------------------------------
module dbi_decoder
    import dbi_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dbi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    input  logic             clear_err
);

    localparam int             PW       = $clog2(WIDTH) + 1;
    localparam int             HALF     = half_of(WIDTH);
    localparam logic [PW-1:0]  HALF_CNT = PW'(HALF);

    if ((WIDTH < 2) || ((WIDTH % 2) != 0) || (WIDTH > POP_MAX_W)) begin : g_bad_width
        $error("dbi_decoder: WIDTH must be even, >= 2 and <= POP_MAX_W");
    end

    logic             accept;
    logic [WIDTH-1:0] decoded;
    logic [PW-1:0]    pop;
    logic             violation;

    assign accept  = in_valid && in_ready;
    assign decoded = in_dbi ? ~in_data : in_data;
    assign pop     = PW'(popcount(POP_MAX_W'(in_data)));

    // The encoder inverts only when the original popcount exceeds HALF, so a
    // legal inverted word has strictly fewer than HALF ones on the wire.
    assign violation = accept && ((pop > HALF_CNT) || (in_dbi && (pop == HALF_CNT)));

    skid_buffer_2 #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (decoded),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= violation;
            if (clear_err) begin
                err_count <= '0;
            end else if (violation && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dbi_decoder.sv
// -----------------------------------------------------------------------------
// tb_dbi_decoder
// Scoreboarded bench for dbi_decoder (WIDTH=8, ERR_W=2). A reference model on
// the rising edge tracks buffer occupancy, expected decoded words (queue) and
// the error counter from the DBI rules; a monitor on the falling edge compares
// every DUT output against it.
// -----------------------------------------------------------------------------
module tb_dbi_decoder;

    localparam int W      = 8;
    localparam int EW     = 2;
    localparam int HALF   = W / 2;
    localparam int CNTMAX = (1 << EW) - 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_dbi;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          err_pulse;
    logic [EW-1:0] err_count;
    logic          clear_err;

    dbi_decoder #(
        .WIDTH (W),
        .ERR_W (EW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dbi    (in_dbi),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .clear_err (clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q[$];
    int           occ          = 0;
    bit           exp_in_ready = 0;
    bit           exp_pulse    = 0;
    int           exp_cnt      = 0;
    bit           started      = 0;
    bit           hold_prev    = 0;
    logic [W-1:0] prev_data;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                exp_q.delete();
                occ          = 0;
                exp_in_ready = 0;
                exp_pulse    = 0;
                exp_cnt      = 0;
                hold_prev    = 0;
                started      = 1;
            end else if (started) begin
                bit acc, emt, viol;
                int p;
                acc  = in_valid && exp_in_ready;
                emt  = (occ > 0) && out_ready;
                p    = $countones(in_data);
                viol = acc && ((p > HALF) || (in_dbi && (p == HALF)));
                if (acc) exp_q.push_back(in_dbi ? ~in_data : in_data);
                occ          = occ + int'(acc) - int'(emt);
                exp_in_ready = (occ < 2);
                exp_pulse    = viol;
                if (clear_err)                     exp_cnt = 0;
                else if (viol && exp_cnt < CNTMAX) exp_cnt++;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("in_ready", in_ready, exp_in_ready);
                check("out_valid", out_valid, occ > 0);
                check("err_pulse", err_pulse, exp_pulse);
                check("err_count", err_count, exp_cnt);
                if (hold_prev) check("out_data_hold", out_data, prev_data);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) check("out_unexpected", out_valid, 0);
                    else                   check("out_data", out_data, exp_q.pop_front());
                end
                hold_prev = out_valid && !out_ready;
                prev_data = out_data;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [W-1:0] d, input logic dbi);
        bit done = 0;
        int k    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_dbi   = dbi;
        while (!done) begin
            @(posedge clk);
            done = in_ready;
            k++;
            if (!done && k > 64) begin
                check("send_timeout", in_ready, 1);
                done = 1;
            end
        end
        #1;
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_dbi   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dbi    = 1'b0;
        out_ready = 1'b0;
        clear_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: single inverted word
        out_ready = 1'b1;
        send(8'h0F, 1'b1);
        idle(3);

        // 2: back-to-back stream of 16 words
        send(8'h03, 1'b0);
        for (int i = 0; i < 15; i++) send(W'($urandom), 1'($urandom));
        idle(4);

        // 3: backpressure with three words
        out_ready = 1'b0;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        fork
            send(8'h33, 1'b0);
            begin
                idle(4);
                out_ready = 1'b1;
            end
        join
        idle(4);

        // 4: violations, starting from a cleared counter
        clear_err = 1'b1;
        idle(1);
        clear_err = 1'b0;
        send(8'hFF, 1'b0);
        send(8'h0F, 1'b1);
        idle(3);
        @(negedge clk);
        check("err_count_after_two", err_count, 2);
        idle(1);

        // 5: saturation, then clear coincident with a violation
        for (int i = 0; i < 5; i++) send(8'hFE, 1'b0);
        idle(2);
        @(negedge clk);
        check("err_count_saturated", err_count, CNTMAX);
        @(posedge clk);
        #1;
        clear_err = 1'b1;
        send(8'hFF, 1'b0);
        clear_err = 1'b0;
        @(negedge clk);
        check("clear_wins_count", err_count, 0);
        check("clear_wins_pulse", err_pulse, 1);
        idle(3);

        // 6: reset with the buffer full
        out_ready = 1'b0;
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        idle(1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_err_count", err_count, 0);
        @(negedge clk);
        check("rst_in_ready_rise", in_ready, 1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        idle(4);

        // random traffic
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_data   = W'($urandom);
            in_dbi    = 1'($urandom);
            out_ready = ($urandom_range(2) != 0);
            clear_err = ($urandom_range(31) == 0);
            rst_n     = ($urandom_range(199) != 0);
            @(posedge clk);
            #1;
        end
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        clear_err = 1'b0;
        out_ready = 1'b1;

        // drain with a bounded wait
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        idle(2);
        check("drain_empty", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
